// File: rtl/crtc_pkg.sv
// Shared definitions for the CPC-style 6845 CRTC subset: register indices,
// reset values and the vertical state encoding.
package crtc_pkg;

  localparam logic [4:0] R0  = 5'd0;
  localparam logic [4:0] R1  = 5'd1;
  localparam logic [4:0] R2  = 5'd2;
  localparam logic [4:0] R3  = 5'd3;
  localparam logic [4:0] R4  = 5'd4;
  localparam logic [4:0] R5  = 5'd5;
  localparam logic [4:0] R6  = 5'd6;
  localparam logic [4:0] R7  = 5'd7;
  localparam logic [4:0] R8  = 5'd8;
  localparam logic [4:0] R9  = 5'd9;
  localparam logic [4:0] R10 = 5'd10;
  localparam logic [4:0] R11 = 5'd11;
  localparam logic [4:0] R12 = 5'd12;
  localparam logic [4:0] R13 = 5'd13;

  typedef enum logic {NORMAL = 1'b0, ADJUST = 1'b1} vstate_t;

  // R8, R10 and R11 accept writes but drive nothing in this subset, so they are not stored.
  typedef struct packed {
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    logic [6:0] r4;
    logic [4:0] r5;
    logic [6:0] r6;
    logic [6:0] r7;
    logic [4:0] r9;
    logic [5:0] r12;
    logic [7:0] r13;
  } crtc_regs_t;

  localparam crtc_regs_t CPC_REGS = '{r0: 8'd63, r1: 8'd40, r2: 8'd46, r3: 8'h8E,
                                      r4: 7'd38, r5: 5'd0, r6: 7'd25, r7: 7'd30,
                                      r9: 5'd7, r12: 6'h30, r13: 8'h00};

  function automatic crtc_regs_t reset_regs(input bit cpc);
    crtc_regs_t v;
    if (cpc) v = CPC_REGS;
    else     v = '0;
    return v;
  endfunction

endpackage

// File: rtl/crtc_regfile.sv
// Write-only CRTC register file: index latch, write decode and width-masked storage.
module crtc_regfile
  import crtc_pkg::*;
#(
  parameter bit CPC_DEFAULTS = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       addr_wr,
  input  logic       data_wr,
  input  logic [7:0] din,
  output crtc_regs_t regs
);

  localparam crtc_regs_t RST_REGS = reset_regs(CPC_DEFAULTS);

  logic [4:0] index_r;
  crtc_regs_t regs_r;

  // Index latch and register writes; an address strobe wins over a data strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_r <= 5'd0;
      regs_r  <= RST_REGS;
    end else if (addr_wr) begin
      index_r <= din[4:0];
    end else if (data_wr) begin
      case (index_r)
        R0:      regs_r.r0  <= din;
        R1:      regs_r.r1  <= din;
        R2:      regs_r.r2  <= din;
        R3:      regs_r.r3  <= din;
        R4:      regs_r.r4  <= din[6:0];
        R5:      regs_r.r5  <= din[4:0];
        R6:      regs_r.r6  <= din[6:0];
        R7:      regs_r.r7  <= din[6:0];
        R9:      regs_r.r9  <= din[4:0];
        R12:     regs_r.r12 <= din[5:0];
        R13:     regs_r.r13 <= din;
        default: regs_r     <= regs_r;
      endcase
    end
  end

  assign regs = regs_r;

endmodule

// File: rtl/crtc_lite_6845.sv
// HD6845 type-0 CRTC subset: character/line counters, sync generators and the
// vertical normal/adjust sequencer producing MA/RA/DISPEN for the gate array.
module crtc_lite_6845
  import crtc_pkg::*;
#(
  parameter int MA_WIDTH     = 14,
  parameter int RA_WIDTH     = 5,
  parameter bit CPC_DEFAULTS = 1'b1
) (
  input  logic                CCLK,
  input  logic                PAD_RESET_n,
  input  logic                ADDR_WR,
  input  logic                DATA_WR,
  input  logic [7:0]          DIN,
  output logic                HSYNC,
  output logic                VSYNC,
  output logic                DISPEN,
  output logic [MA_WIDTH-1:0] MA,
  output logic [RA_WIDTH-1:0] RA
);

  localparam crtc_regs_t             RST_REGS = reset_regs(CPC_DEFAULTS);
  localparam logic [MA_WIDTH-1:0] RST_BASE = MA_WIDTH'({RST_REGS.r12, RST_REGS.r13});

  crtc_regs_t             regs_s;
  logic [7:0]             hcc_r;
  logic [6:0]             vcc_r;
  logic [4:0]             ra_r;
  logic [4:0]             adj_r;
  vstate_t                vstate_r;
  logic [MA_WIDTH-1:0]    row_base_r;
  logic [MA_WIDTH-1:0]    row_next_r;
  logic [3:0]             hs_cnt_r;
  logic [3:0]             vs_cnt_r;
  logic                   hsync_r;
  logic                   vsync_r;

  logic                   eol_s;
  logic [7:0]             hcc_next_s;
  logic                   row_end_s;
  logic                   frame_end_s;
  logic                   row_latch_s;
  logic                   vs_hit_s;
  logic [MA_WIDTH-1:0]    start_s;
  logic [MA_WIDTH-1:0]    row_next_s;

  crtc_regfile #(.CPC_DEFAULTS(CPC_DEFAULTS)) u_regs (
    .clk     (CCLK),
    .rst_n   (PAD_RESET_n),
    .addr_wr (ADDR_WR),
    .data_wr (DATA_WR),
    .din     (DIN),
    .regs    (regs_s)
  );

  assign eol_s       = (hcc_r == regs_s.r0);
  assign hcc_next_s  = eol_s ? 8'd0 : hcc_r + 8'd1;
  assign row_end_s   = (vstate_r == NORMAL) && (ra_r == regs_s.r9);
  assign frame_end_s = eol_s && ((row_end_s && (vcc_r == regs_s.r4) && (regs_s.r5 == 5'd0)) ||
                                 ((vstate_r == ADJUST) && (adj_r == regs_s.r5 - 5'd1)));
  assign row_latch_s = row_end_s && (hcc_r == regs_s.r1);
  assign start_s     = MA_WIDTH'({regs_s.r12, regs_s.r13});
  assign row_next_s  = row_latch_s ? row_base_r + MA_WIDTH'(regs_s.r1) : row_next_r;
  // VSYNC starts on the edge that lands on HCC=0, RA=0 with VCC==R7.
  assign vs_hit_s    = frame_end_s ? (regs_s.r7 == 7'd0)
                                   : (eol_s && row_end_s && (vcc_r + 7'd1 == regs_s.r7));

  // Character counter; an R0 below HCC lets it run through 255.
  always_ff @(posedge CCLK or negedge PAD_RESET_n) begin
    if (!PAD_RESET_n) hcc_r <= 8'd0;
    else              hcc_r <= hcc_next_s;
  end

  // Vertical sequencer: raster/row counters, adjust lines and the MA row base.
  always_ff @(posedge CCLK or negedge PAD_RESET_n) begin
    if (!PAD_RESET_n) begin
      vstate_r   <= NORMAL;
      vcc_r      <= 7'd0;
      ra_r       <= 5'd0;
      adj_r      <= 5'd0;
      row_base_r <= RST_BASE;
      row_next_r <= RST_BASE;
    end else begin
      if (row_latch_s) row_next_r <= row_next_s;
      if (eol_s) begin
        row_base_r <= row_next_s;
        if (frame_end_s) begin
          vstate_r   <= NORMAL;
          vcc_r      <= 7'd0;
          ra_r       <= 5'd0;
          adj_r      <= 5'd0;
          row_base_r <= start_s;
          row_next_r <= start_s;
        end else begin
          case (vstate_r)
            NORMAL: begin
              if (ra_r != regs_s.r9) begin
                ra_r <= ra_r + 5'd1;
              end else begin
                ra_r  <= 5'd0;
                vcc_r <= vcc_r + 7'd1;
                if (vcc_r == regs_s.r4) begin
                  adj_r    <= 5'd0;
                  vstate_r <= ADJUST;
                end
              end
            end
            ADJUST: begin
              ra_r  <= ra_r + 5'd1;
              adj_r <= adj_r + 5'd1;
            end
            default: vstate_r <= NORMAL;
          endcase
        end
      end
    end
  end

  // Horizontal sync: loaded from R3[3:0], counted down per character, no retrigger.
  always_ff @(posedge CCLK or negedge PAD_RESET_n) begin
    if (!PAD_RESET_n) begin
      hsync_r  <= 1'b0;
      hs_cnt_r <= 4'd0;
    end else if (hsync_r) begin
      if (hs_cnt_r == 4'd1) hsync_r <= 1'b0;
      hs_cnt_r <= hs_cnt_r - 4'd1;
    end else if ((hcc_next_s == regs_s.r2) && (regs_s.r3[3:0] != 4'd0)) begin
      hsync_r  <= 1'b1;
      hs_cnt_r <= regs_s.r3[3:0];
    end
  end

  // Vertical sync: loaded from R3[7:4] (0 acts as 16), counted down per line.
  always_ff @(posedge CCLK or negedge PAD_RESET_n) begin
    if (!PAD_RESET_n) begin
      vsync_r  <= 1'b0;
      vs_cnt_r <= 4'd0;
    end else if (vsync_r) begin
      if (eol_s) begin
        if (vs_cnt_r == 4'd1) vsync_r <= 1'b0;
        vs_cnt_r <= vs_cnt_r - 4'd1;
      end
    end else if (vs_hit_s) begin
      vsync_r  <= 1'b1;
      vs_cnt_r <= regs_s.r3[7:4];
    end
  end

  assign HSYNC  = hsync_r;
  assign VSYNC  = vsync_r;
  assign DISPEN = (hcc_r < regs_s.r1) && (vcc_r < regs_s.r6) && (vstate_r == NORMAL);
  assign MA     = row_base_r + MA_WIDTH'(hcc_r);
  assign RA     = RA_WIDTH'(ra_r);

endmodule

// File: tb/tb_crtc_lite_6845.sv
// Directed bench for crtc_lite_6845 with CPC defaults; expected values are
// hand-derived from the CPC timing (64 x 312 lines, 40x25 display).
module tb_crtc_lite_6845;

  logic        CCLK = 1'b0;
  logic        PAD_RESET_n = 1'b0;
  logic        ADDR_WR = 1'b0;
  logic        DATA_WR = 1'b0;
  logic [7:0]  DIN = 8'd0;
  logic        HSYNC, VSYNC, DISPEN;
  logic [13:0] MA;
  logic [4:0]  RA;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int hs_cnt, vs_cnt, de_cnt;

  crtc_lite_6845 #(.MA_WIDTH(14), .RA_WIDTH(5), .CPC_DEFAULTS(1'b1)) dut (
    .CCLK        (CCLK),
    .PAD_RESET_n (PAD_RESET_n),
    .ADDR_WR     (ADDR_WR),
    .DATA_WR     (DATA_WR),
    .DIN         (DIN),
    .HSYNC       (HSYNC),
    .VSYNC       (VSYNC),
    .DISPEN      (DISPEN),
    .MA          (MA),
    .RA          (RA)
  );

  always #5 CCLK = ~CCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge CCLK);
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  // Reset released on a negedge; cyc counts rising edges since then.
  task automatic do_reset();
    PAD_RESET_n = 1'b0;
    ADDR_WR = 1'b0;
    DATA_WR = 1'b0;
    DIN = 8'd0;
    repeat (2) @(negedge CCLK);
    PAD_RESET_n = 1'b1;
    cyc = 0;
  endtask

  task automatic wr_reg(input logic [7:0] idx, input logic [7:0] val);
    ADDR_WR = 1'b1; DIN = idx;
    tick();
    ADDR_WR = 1'b0; DATA_WR = 1'b1; DIN = val;
    tick();
    DATA_WR = 1'b0;
  endtask

  initial begin
    // Tests 1/2: default frame
    PAD_RESET_n = 1'b0;
    repeat (2) @(negedge CCLK);
    chk("rst_hsync", HSYNC, 1'b0);
    chk("rst_vsync", VSYNC, 1'b0);
    chk("rst_ra", RA, 5'd0);
    do_reset();
    chk("rst_ma", MA, 14'h3000);
    chk("rst_dispen", DISPEN, 1'b1);
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
    while (cyc < 19968) begin
      if (cyc < 64) begin
        chk("l0_hsync", HSYNC, (cyc >= 46) && (cyc <= 59));
        chk("l0_dispen", DISPEN, cyc < 40);
        chk("l0_ma", MA, 14'h3000 + 14'(cyc));
      end
      if (cyc == 64)    begin chk("l1_ra", RA, 5'd1); chk("l1_ma", MA, 14'h3000); end
      if (cyc == 512)   begin chk("row1_ma", MA, 14'h3028); chk("row1_ra", RA, 5'd0); end
      if (cyc == 15359) chk("vs_pre", VSYNC, 1'b0);
      if (cyc == 15360) chk("vs_rise", VSYNC, 1'b1);
      if (cyc == 15871) chk("vs_last", VSYNC, 1'b1);
      if (cyc == 15872) chk("vs_fall", VSYNC, 1'b0);
      if (cyc == 19967) chk("frm_end_de", DISPEN, 1'b0);
      if (HSYNC)  hs_cnt++;
      if (VSYNC)  vs_cnt++;
      if (DISPEN) de_cnt++;
      tick();
    end
    chk("frm_ma", MA, 14'h3000);
    chk("frm_ra", RA, 5'd0);
    chk("frm_dispen", DISPEN, 1'b1);
    chk("frm_hs_cycles", hs_cnt, 32'd4368);
    chk("frm_vs_cycles", vs_cnt, 32'd512);
    chk("frm_de_cycles", de_cnt, 32'd8000);

    // Test 3: two adjust lines, R6 raised so DISPEN is gated only by the state
    do_reset();
    wr_reg(8'd5, 8'd2);
    wr_reg(8'd6, 8'd50);
    run_to(19909); chk("adj_pre_de", DISPEN, 1'b1);
    run_to(19968); chk("adj0_ra", RA, 5'd0); chk("adj0_de", DISPEN, 1'b0);
    run_to(19973); chk("adj0_ma", MA, 14'h361D); chk("adj0_de5", DISPEN, 1'b0);
    run_to(20032); chk("adj1_ra", RA, 5'd1); chk("adj1_ma", MA, 14'h3618);
    run_to(20095); chk("adj1_last_ra", RA, 5'd1);
    run_to(20096); chk("adj_frm_ma", MA, 14'h3000); chk("adj_frm_ra", RA, 5'd0);
    chk("adj_frm_de", DISPEN, 1'b1);

    // Test 4: R0=20 written while HCC=40
    do_reset();
    run_to(39);
    wr_reg(8'd0, 8'd20);
    run_to(250); chk("ovr_de", DISPEN, 1'b0);
    run_to(255); chk("ovr_ma255", MA, 14'h30FF); chk("ovr_ra255", RA, 5'd0);
    run_to(256); chk("ovr_wrap_ma", MA, 14'h3000); chk("ovr_wrap_ra", RA, 5'd0);
    run_to(276); chk("ovr_l_ma", MA, 14'h3014); chk("ovr_l_ra", RA, 5'd0);
    run_to(277); chk("ovr_n_ra", RA, 5'd1); chk("ovr_n_ma", MA, 14'h3000);
    run_to(298); chk("ovr_n2_ra", RA, 5'd2);

    // Test 5: R3=0 -> no HSYNC, VSYNC 16 lines
    do_reset();
    wr_reg(8'd3, 8'h00);
    hs_cnt = 0;
    while (cyc < 16500) begin
      if (cyc == 15359) chk("w0_vs_pre", VSYNC, 1'b0);
      if (cyc == 15360) chk("w0_vs_rise", VSYNC, 1'b1);
      if (cyc == 16383) chk("w0_vs_last", VSYNC, 1'b1);
      if (cyc == 16384) chk("w0_vs_fall", VSYNC, 1'b0);
      if (HSYNC) hs_cnt++;
      tick();
    end
    chk("w0_hs_cycles", hs_cnt, 32'd0);

    // Test 6: simultaneous strobes and out-of-range indices
    do_reset();
    ADDR_WR = 1'b1; DATA_WR = 1'b1; DIN = 8'd2;
    tick();
    ADDR_WR = 1'b0; DATA_WR = 1'b0;
    wr_reg(8'd15, 8'd5);
    wr_reg(8'd16, 8'd5);
    run_to(3);  chk("both_hsync", HSYNC, 1'b0);
    run_to(63); chk("idx_ma63", MA, 14'h303F); chk("idx_ra63", RA, 5'd0);
    run_to(64); chk("idx_ra64", RA, 5'd1); chk("idx_ma64", MA, 14'h3000);

    // Asynchronous reset in the middle of VSYNC
    do_reset();
    wr_reg(8'd1, 8'd10);
    run_to(15400); chk("mid_vs", VSYNC, 1'b1);
    #2 PAD_RESET_n = 1'b0;
    #1;
    chk("arst_vsync", VSYNC, 1'b0);
    chk("arst_hsync", HSYNC, 1'b0);
    chk("arst_ma", MA, 14'h3000);
    chk("arst_ra", RA, 5'd0);
    chk("arst_dispen", DISPEN, 1'b1);
    @(negedge CCLK);
    PAD_RESET_n = 1'b1;
    cyc = 0;
    run_to(20);  chk("arst_r1_de", DISPEN, 1'b1);
    run_to(512); chk("arst_row1_ma", MA, 14'h3028);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
